// File: rtl/cannon_step_sequencer.sv
// Cannon-algorithm phase sequencer: load, skew, then SQRT_P rounds of MAC/shift.
// Optional cycle counter output perf_cycles under `CANNON_SEQ_PERF_EN.
module cannon_step_sequencer #(
  parameter int SQRT_P  = 2,
  parameter int P       = SQRT_P * SQRT_P,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             load_en,
  output logic             skew_en,
  output logic             mac_en,
  output logic             shift_en,
  input  logic [P-1:0]     pe_ack,
  output logic [CNT_W-1:0] step_idx
`ifdef CANNON_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, SKEW, MAC, SHIFT, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [P-1:0]     ack_mask_q, ack_mask_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             phase;
  logic             complete;

  assign phase    = (state_q == LOAD) || (state_q == SKEW) ||
                    (state_q == MAC)  || (state_q == SHIFT);
  assign complete = &(ack_mask_q | pe_ack);

  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    ack_mask_d = ack_mask_q;
    tmo_d      = tmo_q;
    step_d     = step_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          step_d  = '0;
        end
      end
      LOAD, SKEW, MAC, SHIFT: begin
        if (first_q) begin
          // Pulse cycle: acks are ignored, the wait counter starts running.
          first_d    = 1'b0;
          ack_mask_d = '0;
          tmo_d      = tmo_q + CNT_W'(1);
        end else if (complete) begin
          unique case (state_q)
            LOAD:    state_d = (SQRT_P == 1) ? MAC : SKEW;
            SKEW:    state_d = MAC;
            MAC:     state_d = (step_q < CNT_W'(SQRT_P - 1)) ? SHIFT : DONE;
            default: begin
              state_d = MAC;
              step_d  = step_q + CNT_W'(1);
            end
          endcase
        end else if (tmo_q == CNT_W'(TIMEOUT)) begin
          state_d = ERR;
        end else begin
          ack_mask_d = ack_mask_q | pe_ack;
          tmo_d      = tmo_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        if (start) begin
          state_d = IDLE;
          step_d  = '0;
        end
      end
    endcase
    if (state_d != state_q && state_d != DONE && state_d != IDLE && state_d != ERR) begin
      first_d    = 1'b1;
      ack_mask_d = '0;
      tmo_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      ack_mask_q <= '0;
      tmo_q      <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      ack_mask_q <= ack_mask_d;
      tmo_q      <= tmo_d;
      step_q     <= step_d;
    end
  end

  assign busy     = phase;
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);
  assign load_en  = (state_q == LOAD)  && first_q;
  assign skew_en  = (state_q == SKEW)  && first_q;
  assign mac_en   = (state_q == MAC)   && first_q;
  assign shift_en = (state_q == SHIFT) && first_q;
  assign step_idx = step_q;

`ifdef CANNON_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && start) begin
      perf_d = '0;
    end else if (phase && perf_q != '1) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule
